// File: rtl/trace_pkg.sv
// Shared definitions for the writeback trace path: the record layout and its pack/unpack helpers.
package trace_pkg;

  localparam int unsigned WB_PC_W  = 32;
  localparam int unsigned WB_REG_W = 5;
  localparam int unsigned WB_VAL_W = 32;
  localparam int unsigned WB_REC_W = WB_PC_W + 1 + WB_REG_W + WB_VAL_W;

  // Field offsets inside a packed record {pc, ena, reg, value}
  localparam int unsigned WB_VAL_LSB = 0;
  localparam int unsigned WB_REG_LSB = WB_VAL_LSB + WB_VAL_W;
  localparam int unsigned WB_ENA_BIT = WB_REG_LSB + WB_REG_W;
  localparam int unsigned WB_PC_LSB  = WB_ENA_BIT + 1;

  typedef struct packed {
    logic [WB_PC_W-1:0]  pc;
    logic                ena;
    logic [WB_REG_W-1:0] rd;
    logic [WB_VAL_W-1:0] value;
  } wb_rec_t;

  function automatic logic [WB_REC_W-1:0] pack_rec(input wb_rec_t r);
    logic [WB_REC_W-1:0] b;
    b = '0;
    b[WB_PC_LSB +: WB_PC_W]   = r.pc;
    b[WB_ENA_BIT]             = r.ena;
    b[WB_REG_LSB +: WB_REG_W] = r.rd;
    b[WB_VAL_LSB +: WB_VAL_W] = r.value;
    return b;
  endfunction

  function automatic wb_rec_t unpack_rec(input logic [WB_REC_W-1:0] b);
    wb_rec_t r;
    r.pc    = b[WB_PC_LSB +: WB_PC_W];
    r.ena   = b[WB_ENA_BIT];
    r.rd    = b[WB_REG_LSB +: WB_REG_W];
    r.value = b[WB_VAL_LSB +: WB_VAL_W];
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with registered storage, occupancy count and wrap-bit pointers.
// rdata is forced to zero while empty so downstream fields read 0 without a valid record.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and occupancy update; simultaneous push and pop leaves cnt unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retired-instruction records from the writeback trace port, tags them with a
// sequence number and buffers them for a slower valid/ready consumer; drops are counted.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SEQ_W       = 16,
  parameter int unsigned CNT_W       = 16,
  parameter bit          CAPTURE_ALL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en,
  input  logic                     debug_wb_have_inst,
  input  logic [31:0]              debug_wb_pc,
  input  logic                     debug_wb_ena,
  input  logic [4:0]               debug_wb_reg,
  input  logic [31:0]              debug_wb_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic                     out_ena,
  output logic [4:0]               out_reg,
  output logic [31:0]              out_value,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  input  logic                     clr_stat
);

  localparam int unsigned FW = WB_REC_W + SEQ_W;

  logic             eff_wr;
  logic             cap;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [SEQ_W-1:0] seq_q;
  wb_rec_t          rec_n;
  wb_rec_t          rec_out;
  logic [FW-1:0]    wdata;
  logic [FW-1:0]    rdata;

  // Writes to x0 are architecturally invisible, so they are normalised to "no write"
  assign eff_wr = debug_wb_ena & (debug_wb_reg != 5'd0);
  assign cap    = trace_en & debug_wb_have_inst & (CAPTURE_ALL | eff_wr);

  always_comb begin
    rec_n.pc    = debug_wb_pc;
    rec_n.ena   = eff_wr;
    rec_n.rd    = eff_wr ? debug_wb_reg : 5'd0;
    rec_n.value = eff_wr ? debug_wb_value : 32'd0;
  end

  assign wdata = {pack_rec(rec_n), seq_q};
  assign pop   = out_valid & out_ready;
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  trace_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rec_out   = unpack_rec(rdata[FW-1:SEQ_W]);
  assign out_valid = ~empty;
  assign out_pc    = rec_out.pc;
  assign out_ena   = rec_out.ena;
  assign out_reg   = rec_out.rd;
  assign out_value = rec_out.value;
  assign out_seq   = rdata[SEQ_W-1:0];

  // Dropped records still consume a number so gaps are visible downstream
  always_ff @(posedge clk) begin
    if (!rst_n) seq_q <= '0;
    else if (cap) seq_q <= seq_q + 1'b1;
  end

  // A drop coinciding with a clear is counted after the clear takes effect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_stat) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer: vector table plus multi-cycle sequences.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_en = 1'b0;
  logic        have = 1'b0;
  logic [31:0] pc = '0;
  logic        ena = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] val = '0;
  logic        ready = 1'b0;
  logic        ready0 = 1'b1;
  logic        clr = 1'b0;

  logic        out_valid, out_ena, overflow;
  logic [31:0] out_pc, out_value;
  logic [4:0]  out_reg, level;
  logic [15:0] out_seq, drop_count;

  logic        out_valid0, out_ena0, overflow0;
  logic [31:0] out_pc0, out_value0;
  logic [4:0]  out_reg0, level0;
  logic [15:0] out_seq0, drop_count0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(16), .SEQ_W(16), .CNT_W(16), .CAPTURE_ALL(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .debug_wb_have_inst(have),
    .debug_wb_pc(pc), .debug_wb_ena(ena), .debug_wb_reg(rd), .debug_wb_value(val),
    .out_valid(out_valid), .out_ready(ready), .out_pc(out_pc), .out_ena(out_ena),
    .out_reg(out_reg), .out_value(out_value), .out_seq(out_seq), .level(level),
    .overflow(overflow), .drop_count(drop_count), .clr_stat(clr)
  );

  wb_trace_buffer #(.DEPTH(16), .SEQ_W(16), .CNT_W(16), .CAPTURE_ALL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .debug_wb_have_inst(have),
    .debug_wb_pc(pc), .debug_wb_ena(ena), .debug_wb_reg(rd), .debug_wb_value(val),
    .out_valid(out_valid0), .out_ready(ready0), .out_pc(out_pc0), .out_ena(out_ena0),
    .out_reg(out_reg0), .out_value(out_value0), .out_seq(out_seq0), .level(level0),
    .overflow(overflow0), .drop_count(drop_count0), .clr_stat(clr)
  );

  typedef struct {
    logic        en;
    logic        hv;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        x_valid;
    logic [31:0] x_pc;
    logic        x_ena;
    logic [4:0]  x_rd;
    logic [31:0] x_val;
    logic [15:0] x_seq;
    logic        x0_valid;
    logic [15:0] x0_seq;
  } vec_t;

  vec_t vecs[7];
  logic [85:0] q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; have = 1'b0; ready = 1'b0; clr = 1'b0; trace_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [85:0] cur_rec();
    return {out_pc, out_ena, out_reg, out_value, out_seq};
  endfunction

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_level", 128'(level), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_drop_count", 128'(drop_count), 128'(0));
    check("rst_data", 128'({out_pc, out_seq}), 128'(0));

    // Vector table: one record per cycle, consumer always ready
    vecs[0] = '{1'b1, 1'b1, 32'h4,  1'b1, 5'd5,  32'h1234,     1'b1, 32'h4,  1'b1, 5'd5,  32'h1234,     16'd0, 1'b1, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 32'h8,  1'b1, 5'd0,  32'hDEAD,     1'b1, 32'h8,  1'b0, 5'd0,  32'h0,        16'd1, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 32'hC,  1'b0, 5'd7,  32'hBEEF,     1'b1, 32'hC,  1'b0, 5'd0,  32'h0,        16'd2, 1'b0, 16'd0};
    vecs[3] = '{1'b0, 1'b1, 32'h10, 1'b1, 5'd3,  32'h55,       1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        16'd0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 32'h14, 1'b1, 5'd3,  32'h55,       1'b0, 32'h0,  1'b0, 5'd0,  32'h0,        16'd0, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 1'b1, 32'h18, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 32'h18, 1'b1, 5'd31, 32'hFFFFFFFF, 16'd3, 1'b1, 16'd1};
    vecs[6] = '{1'b1, 1'b1, 32'h1C, 1'b1, 5'd1,  32'h0,        1'b1, 32'h1C, 1'b1, 5'd1,  32'h0,        16'd4, 1'b1, 16'd2};
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      trace_en = vecs[i].en; have = vecs[i].hv; pc = vecs[i].pc;
      ena = vecs[i].ena; rd = vecs[i].rd; val = vecs[i].val;
      step();
      check($sformatf("vec%0d_rec", i), 128'({out_valid, out_pc, out_ena, out_reg, out_value, out_seq}),
            128'({vecs[i].x_valid, vecs[i].x_pc, vecs[i].x_ena, vecs[i].x_rd, vecs[i].x_val, vecs[i].x_seq}));
      check($sformatf("vec%0d_cap0", i), 128'({out_valid0, out_seq0}),
            128'({vecs[i].x0_valid, vecs[i].x0_seq}));
    end
    trace_en = 1'b1; have = 1'b0;
    step();
    check("single_then_empty", 128'(out_valid), 128'(0));

    // Overflow: 20 caps into a 16-deep buffer with no consumer
    do_reset();
    ena = 1'b1;
    for (int i = 0; i < 20; i++) begin
      have = 1'b1; pc = 32'(i * 4); rd = 5'((i % 31) + 1); val = 32'(i);
      step();
    end
    have = 1'b0;
    check("ovf_level", 128'(level), 128'(16));
    check("ovf_flag", 128'(overflow), 128'(1));
    check("ovf_drop_count", 128'(drop_count), 128'(4));
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf_drain%0d", k), 128'({out_valid, out_pc, out_seq}), 128'({1'b1, 32'(k * 4), 16'(k)}));
      step();
    end
    check("ovf_drained", 128'(out_valid), 128'(0));
    have = 1'b1; pc = 32'h100;
    step();
    have = 1'b0;
    check("ovf_next_seq", 128'({out_valid, out_seq}), 128'({1'b1, 16'd20}));

    // Full with simultaneous push and pop
    do_reset();
    ena = 1'b1; rd = 5'd2;
    for (int i = 0; i < 16; i++) begin
      have = 1'b1; pc = 32'(i);
      step();
    end
    check("full_level", 128'(level), 128'(16));
    ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      have = 1'b1; pc = 32'(16 + j);
      check($sformatf("full_pp_seq%0d", j), 128'(out_seq), 128'(j));
      step();
      check($sformatf("full_pp_level%0d", j), 128'(level), 128'(16));
    end
    have = 1'b0;
    check("full_pp_drops", 128'({overflow, drop_count}), 128'(0));

    // Backpressure against a reference queue
    do_reset();
    q.delete();
    begin
      int caps = 0, cyc = 0, drops = 0;
      logic [15:0] seq_m = '0;
      logic stalled = 1'b0;
      logic [85:0] snap = '0;
      logic eff;
      while ((caps < 200 || q.size() != 0 || out_valid) && cyc < 2000) begin
        cyc++;
        have  = (caps < 200) ? 1'($urandom % 2) : 1'b0;
        pc    = $urandom; ena = 1'($urandom % 2); rd = 5'($urandom % 32); val = $urandom;
        ready = ($urandom % 4) != 0;
        if (stalled) check("bp_stable", 128'({out_valid, cur_rec()}), 128'({1'b1, snap}));
        if (out_valid && ready) begin
          if (q.size() == 0) check("bp_unexpected_valid", 128'(out_valid), 128'(0));
          else begin
            check("bp_stream", 128'(cur_rec()), 128'(q[0]));
            void'(q.pop_front());
          end
        end
        stalled = out_valid && !ready;
        snap    = cur_rec();
        if (have) begin
          eff = ena && (rd != 5'd0);
          if (q.size() == 16) drops++;
          else q.push_back({pc, eff, eff ? rd : 5'd0, eff ? val : 32'd0, seq_m});
          seq_m++;
          caps++;
        end
        step();
      end
      check("bp_budget", 128'(cyc < 2000), 128'(1));
      check("bp_end", 128'({out_valid, level}), 128'(0));
      check("bp_drops", 128'({overflow, drop_count}), 128'({drops != 0, 16'(drops)}));
    end

    // Reset mid-operation with 7 stored records
    do_reset();
    ena = 1'b1; rd = 5'd9; val = 32'h77;
    for (int i = 0; i < 7; i++) begin
      have = 1'b1; pc = 32'h200 + 32'(i);
      step();
    end
    check("mid_level7", 128'(level), 128'(7));
    rst_n = 1'b0; pc = 32'h300;
    step();
    rst_n = 1'b1;
    check("mid_rst", 128'({out_valid, level}), 128'(0));
    step();
    have = 1'b0;
    check("mid_seq_restart", 128'({out_valid, out_pc, out_seq}), 128'({1'b1, 32'h300, 16'd0}));

    // clr_stat coinciding with a drop
    do_reset();
    for (int i = 0; i < 18; i++) begin
      have = 1'b1; pc = 32'(i);
      step();
    end
    check("clr_pre", 128'({overflow, drop_count}), 128'({1'b1, 16'd2}));
    clr = 1'b1;
    step();
    check("clr_with_drop", 128'({overflow, drop_count}), 128'({1'b1, 16'd1}));
    have = 1'b0;
    step();
    clr = 1'b0;
    check("clr_alone", 128'({overflow, drop_count}), 128'(0));
    check("clr_keeps_fifo", 128'({level, out_seq}), 128'({5'd16, 16'd0}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
